// File: rtl/hv_bundle.sv
// rtl/hv_bundle.sv - bitwise majority bundling of NUM_VEC streamed hypervectors into one prototype HV.
// Optional HV_BUNDLE_TIEBREAK_EN: ties resolve to an alternating 0101/1010 pattern instead of 0.
module hv_bundle #(
  parameter int WORDS = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 8
) (
  input  logic             AXIS_ACLK,
  input  logic             AXIS_ARESETN,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             S_AXIS_TVALID,
  output logic             S_AXIS_TREADY,
  input  logic [63:0]      S_AXIS_TDATA,
  input  logic             S_AXIS_TLAST,
  output logic             M_AXIS_TVALID,
  output logic [63:0]      M_AXIS_TDATA,
  output logic [7:0]       M_AXIS_TSTRB,
  output logic             M_AXIS_TLAST,
  input  logic             M_AXIS_TREADY
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    word_idx_q, word_idx_d;
  logic [AW-1:0]    emit_idx_q, emit_idx_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic             err_q, err_d;
  logic [63:0]      tdata_q, tdata_d;
  logic             tlast_q, tlast_d;
  logic [CNT_W-1:0] cnt_q [WORDS][64];

  logic          s_fire;
  logic          last_word;
  logic [AW-1:0] sel;
  logic [63:0]   maj_word;

  assign S_AXIS_TREADY = (state_q == ACCUM);
  assign M_AXIS_TVALID = (state_q == EMIT);
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TSTRB  = 8'hff;
  assign busy          = (state_q != IDLE) && (state_q != DONE);
  assign done          = (state_q == DONE);
  assign err           = err_q;

  assign s_fire    = S_AXIS_TVALID && S_AXIS_TREADY;
  assign last_word = (word_idx_q == LAST);

  // Word 0 is preloaded on the final input beat (only word WORDS-1 is still being written then).
  assign sel = (state_q == EMIT) ? emit_idx_q + AW'(1) : '0;

  always_comb begin
    logic [CNT_W:0] twice;
    logic [CNT_W:0] nv;
    maj_word = '0;
    nv = {1'b0, num_vec_q};
    for (int b = 0; b < 64; b++) begin
      twice = {cnt_q[sel][b], 1'b0};
      if (twice > nv) begin
        maj_word[b] = 1'b1;
      end else if (twice == nv) begin
`ifdef HV_BUNDLE_TIEBREAK_EN
        maj_word[b] = (b % 2 == 0) ^ sel[0];
`else
        maj_word[b] = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    emit_idx_d = emit_idx_q;
    vec_cnt_d  = vec_cnt_q;
    num_vec_d  = num_vec_q;
    err_d      = err_q;
    tdata_d    = tdata_q;
    tlast_d    = tlast_q;
    case (state_q)
      IDLE: begin
        if (start && (num_vec != '0)) begin
          state_d    = ACCUM;
          num_vec_d  = num_vec;
          err_d      = 1'b0;
          word_idx_d = '0;
          vec_cnt_d  = '0;
        end
      end
      ACCUM: begin
        if (s_fire) begin
          word_idx_d = last_word ? '0 : word_idx_q + AW'(1);
          if (last_word) vec_cnt_d = vec_cnt_q + CNT_W'(1);
          // Framing comes from the word index; a misplaced TLAST only flags it.
          if (S_AXIS_TLAST != last_word) err_d = 1'b1;
          if (last_word && (vec_cnt_q == num_vec_q - CNT_W'(1))) begin
            state_d    = EMIT;
            emit_idx_d = '0;
            tdata_d    = maj_word;
            tlast_d    = (LAST == '0);
          end
        end
      end
      EMIT: begin
        if (M_AXIS_TREADY) begin
          if (emit_idx_q == LAST) begin
            state_d = DONE;
            tdata_d = '0;
            tlast_d = 1'b0;
          end else begin
            emit_idx_d = emit_idx_q + AW'(1);
            tdata_d    = maj_word;
            tlast_d    = (emit_idx_q + AW'(1) == LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      emit_idx_q <= '0;
      vec_cnt_q  <= '0;
      num_vec_q  <= '0;
      err_q      <= 1'b0;
      tdata_q    <= '0;
      tlast_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      emit_idx_q <= emit_idx_d;
      vec_cnt_q  <= vec_cnt_d;
      num_vec_q  <= num_vec_d;
      err_q      <= err_d;
      tdata_q    <= tdata_d;
      tlast_q    <= tlast_d;
    end
  end

  // The first vector overwrites its counters, so no clear pass is needed between jobs.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      for (int w = 0; w < WORDS; w++)
        for (int b = 0; b < 64; b++)
          cnt_q[w][b] <= '0;
    end else if (s_fire) begin
      for (int b = 0; b < 64; b++)
        cnt_q[word_idx_q][b] <= ((vec_cnt_q == '0) ? '0 : cnt_q[word_idx_q][b])
                                + CNT_W'(S_AXIS_TDATA[b]);
    end
  end

endmodule

// File: tb/tb_hv_bundle.sv
// tb/tb_hv_bundle.sv - directed-vector bench for hv_bundle.
module tb_hv_bundle;

  localparam int WORDS = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vec = '0;
  logic             busy, done, err;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic [63:0]      s_tdata = '0;
  logic             s_tlast = 1'b0;
  logic             m_tvalid;
  logic [63:0]      m_tdata;
  logic [7:0]       m_tstrb;
  logic             m_tlast;
  logic             m_tready = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  hv_bundle #(.WORDS(WORDS), .AW(AW), .CNT_W(CNT_W)) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESETN  (rst_n),
    .start         (start),
    .num_vec       (num_vec),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TLAST  (s_tlast),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TSTRB  (m_tstrb),
    .M_AXIS_TLAST  (m_tlast),
    .M_AXIS_TREADY (m_tready)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // kind 0: {A5A5_0000|k, k}; 1: all ones; 2: all zeros
  function automatic logic [63:0] in_word(input int kind, input int k);
    case (kind)
      0:       return {32'hA5A5_0000 | 32'(k), 32'(k)};
      1:       return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return 64'h0;
    endcase
  endfunction

  // kind 3: one-one / one-zero tie
  function automatic logic [63:0] exp_word(input int kind, input int k);
    if (kind != 3) return in_word(kind, k);
`ifdef HV_BUNDLE_TIEBREAK_EN
    return (k % 2 == 0) ? 64'h5555_5555_5555_5555 : 64'hAAAA_AAAA_AAAA_AAAA;
`else
    return 64'h0;
`endif
  endfunction

  task automatic do_start(input int nv);
    start   = 1'b1;
    num_vec = CNT_W'(nv);
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic send_hv(input int kind, input int last_at, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      int cyc;
      s_tvalid = 1'b1;
      s_tdata  = in_word(kind, k);
      s_tlast  = (k == last_at);
      cyc = 0;
      while (!s_tready && cyc < 50) begin
        @(negedge clk);
        cyc++;
      end
      if (cyc >= 50) check_vec("s_tready_timeout", 64'(s_tready), 64'd1);
      @(negedge clk);
      if (last_at != WORDS - 1 && k == last_at) check_vec("err_on_bad_tlast", 64'(err), 64'd1);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
  endtask

  task automatic recv_hv(input int kind, input bit stall);
    int          k;
    int          cyc;
    bit          stalled;
    logic [63:0] hold_d;
    logic        hold_l;
    k = 0;
    cyc = 0;
    stalled = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    check_vec("m_tvalid_latency", 64'(m_tvalid), 64'd1);
    check_vec("s_tready_drop", 64'(s_tready), 64'd0);
    check_vec("m_tstrb", 64'(m_tstrb), 64'hff);
    while (k < WORDS && cyc < 400) begin
      m_tready = stall ? ((cyc % 2) == 1) : 1'b1;
      if (stalled) begin
        check_vec("stall_tdata", m_tdata, hold_d);
        check_vec("stall_tlast", 64'(m_tlast), 64'(hold_l));
        check_vec("stall_tvalid", 64'(m_tvalid), 64'd1);
      end
      if (m_tvalid && m_tready) begin
        check_vec($sformatf("tdata[%0d]", k), m_tdata, exp_word(kind, k));
        check_vec($sformatf("tlast[%0d]", k), 64'(m_tlast), 64'(k == WORDS - 1));
        k++;
        stalled = 1'b0;
      end else begin
        stalled = m_tvalid;
        hold_d  = m_tdata;
        hold_l  = m_tlast;
      end
      @(negedge clk);
      cyc++;
    end
    m_tready = 1'b0;
    check_vec("beat_count", 64'(k), 64'(WORDS));
    check_vec("done_pulse", 64'(done), 64'd1);
    check_vec("busy_at_done", 64'(busy), 64'd0);
    check_vec("no_extra_beat", 64'(m_tvalid), 64'd0);
    @(negedge clk);
    check_vec("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_vec("rst_busy", 64'(busy), 64'd0);
    check_vec("rst_done", 64'(done), 64'd0);
    check_vec("rst_err", 64'(err), 64'd0);
    check_vec("rst_s_tready", 64'(s_tready), 64'd0);
    check_vec("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check_vec("rst_m_tlast", 64'(m_tlast), 64'd0);
    check_vec("rst_m_tdata", m_tdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // num_vec == 0 must be ignored
    do_start(0);
    for (int i = 0; i < 3; i++) begin
      check_vec("nv0_busy", 64'(busy), 64'd0);
      check_vec("nv0_done", 64'(done), 64'd0);
      check_vec("nv0_s_tready", 64'(s_tready), 64'd0);
      @(negedge clk);
    end

    // T1: single vector passes through
    do_start(1);
    check_vec("t1_busy", 64'(busy), 64'd1);
    check_vec("t1_err", 64'(err), 64'd0);
    send_hv(0, WORDS - 1, WORDS);
    recv_hv(0, 1'b0);

    // T2: 2 of 3 ones; a second start mid-job must not reload num_vec
    do_start(3);
    do_start(1);
    send_hv(1, WORDS - 1, WORDS);
    send_hv(1, WORDS - 1, WORDS);
    send_hv(2, WORDS - 1, WORDS);
    check_vec("t2_err", 64'(err), 64'd0);
    recv_hv(1, 1'b0);

    // T3: exact tie
    do_start(2);
    send_hv(1, WORDS - 1, WORDS);
    send_hv(2, WORDS - 1, WORDS);
    recv_hv(3, 1'b0);

    // T4: T2 with downstream back-pressure
    do_start(3);
    send_hv(1, WORDS - 1, WORDS);
    send_hv(1, WORDS - 1, WORDS);
    send_hv(2, WORDS - 1, WORDS);
    recv_hv(1, 1'b1);

    // T5: TLAST on word 10, none on word 31
    do_start(1);
    send_hv(0, 10, WORDS);
    recv_hv(0, 1'b0);
    check_vec("t5_err_sticky", 64'(err), 64'd1);
    do_start(1);
    check_vec("t5_err_cleared", 64'(err), 64'd0);

    // T6: reset after 5 beats, then a clean all-zeros job
    send_hv(1, WORDS - 1, 5);
    rst_n = 1'b0;
    #1;
    check_vec("t6_busy", 64'(busy), 64'd0);
    check_vec("t6_s_tready", 64'(s_tready), 64'd0);
    check_vec("t6_m_tvalid", 64'(m_tvalid), 64'd0);
    check_vec("t6_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(1);
    send_hv(2, WORDS - 1, WORDS);
    recv_hv(2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
